// File: rtl/dma_rd_burst_engine.sv
`default_nettype none
// ============================================================================
// dma_rd_burst_engine: splits a read job into page-safe bursts and streams beats
// Revision: 1.0
// ============================================================================
module dma_rd_burst_engine #(
   parameter int ADDR_WIDTH      = 64,
   parameter int DATA_WIDTH      = 512,
   parameter int MAX_BURST       = 64,
   parameter int MAX_OUTSTANDING = 4,
   parameter int FIFO_DEPTH      = 128,
   parameter int REVERSE_BYTES   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [31:0]           length,
   output logic                  rd_req,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [7:0]            rd_len,
   input  logic                  rd_req_ack,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_data_valid,
   output logic                  rd_data_taken,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic                  idle,
   output logic                  done,
   output logic                  err
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int BSH   = $clog2(BYTES);
   localparam int FAW   = $clog2(FIFO_DEPTH);
   localparam int CW    = FAW + 1;
   localparam int OCW   = $clog2(MAX_OUTSTANDING + 1);
   localparam int OPW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [31:0]  C_DEPTH = FIFO_DEPTH;
   localparam logic [31:0]  C_MAXO  = MAX_OUTSTANDING;
   localparam logic [OPW-1:0] C_OLAST = OPW'(MAX_OUTSTANDING - 1);

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_REQ, S_DRAIN, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d, rd_addr_q, rd_addr_d;
   logic [32:0]            rem_q, rem_d, exp_q, exp_d;
   logic [8:0]             burst_q, burst_d, bcnt_q, bcnt_d;
   logic                   rd_req_q, rd_req_d, err_q, err_d, done_q, done_d, idle_q, idle_d;
   logic [7:0]             rd_len_q, rd_len_d;
   logic [CW-1:0]          reserved_q, reserved_d, count_q, count_d;
   logic [OCW-1:0]         outst_q, outst_d;
   logic [8:0]             blen_q [MAX_OUTSTANDING];
   logic [8:0]             blen_d [MAX_OUTSTANDING];
   logic [OPW-1:0]         bwp_q, bwp_d, brp_q, brp_d;
   logic [FAW-1:0]         wp_q, wp_d, rp_q, rp_d;
   logic [DATA_WIDTH:0]    mem_q [FIFO_DEPTH];

   logic                   w_take, w_ack, w_pop, w_bdone, w_credit;
   logic [32:0]            w_total, w_min;
   logic [12:0]            w_page_beats;
   logic [8:0]             w_burst, w_cand;
   logic [DATA_WIDTH-1:0]  w_head;

   assign w_take = rd_data_valid && (exp_q != '0);
   assign w_ack  = rd_req_q && rd_req_ack;
   assign w_pop  = (count_q != '0) && out_ready;

   always_comb begin
      w_total      = ({1'b0, length} + 33'(BYTES - 1)) >> BSH;
      w_page_beats = (13'h1000 - {1'b0, addr_q[11:0]}) >> BSH;
      w_min        = 33'(MAX_BURST);
      if (rem_q < w_min) w_min = rem_q;
      if (33'(w_page_beats) < w_min) w_min = 33'(w_page_beats);
      w_burst      = w_min[8:0];
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      exp_d      = exp_q;
      burst_d    = burst_q;
      bcnt_d     = bcnt_q;
      rd_req_d   = rd_req_q;
      rd_addr_d  = rd_addr_q;
      rd_len_d   = rd_len_q;
      err_d      = err_q;
      done_d     = 1'b0;
      reserved_d = reserved_q;
      count_d    = count_q;
      outst_d    = outst_q;
      blen_d     = blen_q;
      bwp_d      = bwp_q;
      brp_d      = brp_q;
      wp_d       = wp_q;
      rp_d       = rp_q;
      w_bdone    = 1'b0;

      if (w_take) begin
         wp_d  = wp_q + 1'b1;
         exp_d = exp_q - 1'b1;
      end
      if (w_pop) rp_d = rp_q + 1'b1;
      case ({w_take, w_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (rd_data_valid && exp_q == '0) err_d = 1'b1;

      if (w_ack) reserved_d = reserved_d + CW'(burst_q);
      if (w_take && reserved_d != '0) reserved_d = reserved_d - 1'b1;

      // Burst-length FIFO tells us when a burst's final beat has returned.
      if (w_take && outst_q != '0) begin
         if (bcnt_q + 9'd1 == blen_q[brp_q]) begin
            bcnt_d  = '0;
            brp_d   = (brp_q == C_OLAST) ? '0 : brp_q + 1'b1;
            w_bdone = 1'b1;
         end else begin
            bcnt_d = bcnt_q + 9'd1;
         end
      end
      if (w_ack) begin
         blen_d[bwp_q] = burst_q;
         bwp_d         = (bwp_q == C_OLAST) ? '0 : bwp_q + 1'b1;
      end
      case ({w_ack, w_bdone})
         2'b10:   outst_d = outst_q + 1'b1;
         2'b01:   outst_d = outst_q - 1'b1;
         default: outst_d = outst_q;
      endcase

      // Credit is judged on next-cycle occupancy so rd_req can be a flop.
      w_cand   = (state_q == S_CALC) ? w_burst : burst_q;
      w_credit = (32'(outst_d) < C_MAXO) &&
                 (32'(count_d) + 32'(reserved_d) + 32'(w_cand) <= C_DEPTH);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d  = {src_addr[ADDR_WIDTH-1:BSH], BSH'(0)};
               rem_d   = w_total;
               exp_d   = w_total;
               err_d   = 1'b0;
               state_d = (w_total == '0) ? S_DONE : S_CALC;
               done_d  = (w_total == '0);
            end
         end
         S_CALC: begin
            burst_d   = w_burst;
            rd_addr_d = addr_q;
            rd_len_d  = 8'(w_burst - 9'd1);
            rd_req_d  = w_credit;
            state_d   = S_REQ;
         end
         S_REQ: begin
            if (rd_req_q) begin
               if (w_ack) begin
                  addr_d   = addr_q + ADDR_WIDTH'({burst_q, BSH'(0)});
                  rem_d    = rem_q - 33'(burst_q);
                  rd_req_d = 1'b0;
                  state_d  = (rem_q == 33'(burst_q)) ? S_DRAIN : S_CALC;
               end
            end else begin
               rd_req_d = w_credit;
            end
         end
         S_DRAIN: begin
            if (exp_d == '0 && count_d == '0) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      idle_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         exp_q      <= '0;
         burst_q    <= '0;
         bcnt_q     <= '0;
         rd_req_q   <= 1'b0;
         rd_addr_q  <= '0;
         rd_len_q   <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         idle_q     <= 1'b1;
         reserved_q <= '0;
         count_q    <= '0;
         outst_q    <= '0;
         blen_q     <= '{default: '0};
         bwp_q      <= '0;
         brp_q      <= '0;
         wp_q       <= '0;
         rp_q       <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         exp_q      <= exp_d;
         burst_q    <= burst_d;
         bcnt_q     <= bcnt_d;
         rd_req_q   <= rd_req_d;
         rd_addr_q  <= rd_addr_d;
         rd_len_q   <= rd_len_d;
         err_q      <= err_d;
         done_q     <= done_d;
         idle_q     <= idle_d;
         reserved_q <= reserved_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         blen_q     <= blen_d;
         bwp_q      <= bwp_d;
         brp_q      <= brp_d;
         wp_q       <= wp_d;
         rp_q       <= rp_d;
      end
   end

   // Each entry carries its job-last flag in the top bit.
   always_ff @(posedge clk) begin
      if (w_take) mem_q[wp_q] <= {exp_q == 33'd1, rd_data};
   end

   assign w_head = mem_q[rp_q][DATA_WIDTH-1:0];

   generate
      if (REVERSE_BYTES != 0) begin : g_rev
         for (genvar i = 0; i < BYTES; i++) begin : g_byte
            assign out_data[i*8 +: 8] = w_head[(BYTES-1-i)*8 +: 8];
         end
      end else begin : g_pass
         assign out_data = w_head;
      end
   endgenerate

   assign rd_req        = rd_req_q;
   assign rd_addr       = rd_addr_q;
   assign rd_len        = rd_len_q;
   assign rd_data_taken = 1'b1;
   assign out_valid     = (count_q != '0);
   assign out_last      = out_valid && mem_q[rp_q][DATA_WIDTH];
   assign idle          = idle_q;
   assign done          = done_q;
   assign err           = err_q;

endmodule
`default_nettype wire
